// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retire trace FIFO.
package retire_trace_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_addr;
        logic        rd_wren;
        logic [31:0] rd_data;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

endpackage

// File: rtl/retire_trace_mem.sv
// Trace entry storage: synchronous write, asynchronous read at the head pointer.
module retire_trace_mem
    import retire_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  trace_entry_t             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output trace_entry_t             o_rd_data
);

    // Storage needs no reset: the top masks the read data while the FIFO is empty.
    trace_entry_t mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/retire_trace_fifo.sv
// Retired-instruction trace FIFO with instret/drop counters and stall request.
// Optional build macro RETIRE_TRACE_SKIP_NOP_EN: canonical NOPs are neither queued nor counted.
module retire_trace_fifo
    import retire_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_retire_vld,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_inst,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_rd_wren,
    input  logic [31:0]      i_rd_data,
    output logic             o_trace_valid,
    input  logic             i_trace_ready,
    output logic [31:0]      o_trace_pc,
    output logic [31:0]      o_trace_inst,
    output logic [4:0]       o_trace_rd_addr,
    output logic             o_trace_rd_wren,
    output logic [31:0]      o_trace_rd_data,
    output logic             o_stall_req,
    output logic [CNT_W-1:0] o_instret,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic             full, pop, push, drop, retire_cnt;
    logic [CNT_W-1:0] instret, drop_cnt;
    logic             stall;
    trace_entry_t     wr_entry, head;

`ifdef RETIRE_TRACE_SKIP_NOP_EN
    assign retire_cnt = i_retire_vld & (i_inst != NOP_INST);
`else
    assign retire_cnt = i_retire_vld;
`endif

    // Valid is derived purely from registered count, so there is no i_* -> o_trace_* path.
    assign o_trace_valid = (count != '0);
    assign full          = (count == FULL_CNT);
    assign pop           = o_trace_valid & i_trace_ready;
    assign push          = retire_cnt & (~full | pop) & ~i_clr;
    assign drop          = retire_cnt & full & ~pop & ~i_clr;

    assign wr_entry = '{pc: i_pc, inst: i_inst, rd_addr: i_rd_addr,
                        rd_wren: i_rd_wren, rd_data: i_rd_data};

    always_comb begin
        count_nxt = count;
        if (i_clr) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            stall    <= 1'b0;
            instret  <= '0;
            drop_cnt <= '0;
        end else begin
            count <= count_nxt;
            // The spare slot left by asserting at DEPTH-1 absorbs the retirement already in flight.
            stall <= (count_nxt >= STALL_CNT);
            if (i_clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                instret  <= '0;
                drop_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (retire_cnt) instret <= instret + 1'b1;
                if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    retire_trace_mem #(.DEPTH(DEPTH)) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr),
        .i_wr_data (wr_entry),
        .i_rd_addr (rd_ptr),
        .o_rd_data (head)
    );

    assign o_trace_pc      = o_trace_valid ? head.pc      : '0;
    assign o_trace_inst    = o_trace_valid ? head.inst    : '0;
    assign o_trace_rd_addr = o_trace_valid ? head.rd_addr : '0;
    assign o_trace_rd_wren = o_trace_valid ? head.rd_wren : 1'b0;
    assign o_trace_rd_data = o_trace_valid ? head.rd_data : '0;
    assign o_stall_req     = stall;
    assign o_instret       = instret;
    assign o_drop_cnt      = drop_cnt;

endmodule
